// File: rtl/mem_1r2w.sv
// Two-write, one-read synchronous memory built from two 1w1r banks plus a live-value table.
// Optional same-cycle write-to-read bypass is enabled by defining MEM_1R2W_BYPASS_EN.
module mem_1r2w #(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write0,
  input  logic [ELEMENTS_W-1:0] writeaddress0,
  input  logic [WIDTH-1:0]      writedata0,
  input  logic                  write1,
  input  logic [ELEMENTS_W-1:0] writeaddress1,
  input  logic [WIDTH-1:0]      writedata1,
  input  logic                  read,
  input  logic [ELEMENTS_W-1:0] readaddress,
  output logic [WIDTH-1:0]      readdata
);

  localparam int ELEMENTS = 2 ** ELEMENTS_W;

  logic [WIDTH-1:0]    bank0_q [ELEMENTS];
  logic [WIDTH-1:0]    bank1_q [ELEMENTS];
  logic [ELEMENTS-1:0] lvt_q, lvt_d;
  logic [WIDTH-1:0]    readdata_q, readdata_d;
  logic [WIDTH-1:0]    bank_rdata;

  // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lvt_d = lvt_q;
    if (write0) lvt_d[writeaddress0] = 1'b0;
    // Port 1 is applied last so it owns the word on a same-address collision.
    if (write1) lvt_d[writeaddress1] = 1'b1;
  end

  always_comb begin
    bank_rdata = lvt_q[readaddress] ? bank1_q[readaddress] : bank0_q[readaddress];
    readdata_d = readdata_q;
    if (read) begin
      readdata_d = bank_rdata;
`ifdef MEM_1R2W_BYPASS_EN
      if (write1 && (writeaddress1 == readaddress)) begin
        readdata_d = writedata1;
      end else if (write0 && (writeaddress0 == readaddress)) begin
        readdata_d = writedata0;
      end
`endif
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvt_q      <= '0;
      readdata_q <= '0;
    end else begin
      lvt_q      <= lvt_d;
      readdata_q <= readdata_d;
    end
  end

  // NOTE: storage arrays carry no reset; resetting them would turn RAM into a flop array.
  always_ff @(posedge clk) begin
    if (rst_n && write0) bank0_q[writeaddress0] <= writedata0;
  end

  always_ff @(posedge clk) begin
    if (rst_n && write1) bank1_q[writeaddress1] <= writedata1;
  end

  assign readdata = readdata_q;

endmodule
